// File: rtl/audio_filter_pkg.sv
// Shared constants and types for the first-order IIR audio filter.
package audio_filter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_COEF_W = 16;

  localparam logic [1:0] FILT_BYPASS = 2'd0;
  localparam logic [1:0] FILT_LP     = 2'd1;
  localparam logic [1:0] FILT_HP     = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    MUL,
    DONE
  } filt_state_t;

endpackage

// File: rtl/iir_mul_sat.sv
// Combinational t*alpha (alpha unsigned Q0.COEF_W), floor shift, optional base add,
// and saturation to DATA_W. Shared by all channels of the filter.
module iir_mul_sat
  import audio_filter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic signed [DATA_W+1:0] t,
  input  logic        [COEF_W-1:0] alpha,
  input  logic signed [DATA_W-1:0] base,
  input  logic                     add_base,
  output logic signed [DATA_W-1:0] y
);

  localparam int PW = DATA_W + COEF_W + 3;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] t_ext;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] base_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] sum;

  always_comb begin
    t_ext    = {{(PW-DATA_W-2){t[DATA_W+1]}}, t};
    a_ext    = {{(PW-COEF_W){1'b0}}, alpha};
    base_ext = {{(PW-DATA_W){base[DATA_W-1]}}, base};
    prod     = t_ext * a_ext;
    // Arithmetic shift rounds toward -inf, matching the reference model.
    sum      = prod >>> COEF_W;
    if (add_base) sum = sum + base_ext;
    if (sum > SAT_MAX)      y = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) y = SAT_MIN[DATA_W-1:0];
    else                    y = sum[DATA_W-1:0];
  end

endmodule

// File: rtl/audio_iir_filter.sv
// Multi-channel first-order IIR (bypass / low-pass / high-pass) on the codec bit clock.
// Frames start on LR clock rising edges; channels share one multiplier, 2 cycles each.
module audio_iir_filter
  import audio_filter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CHANNELS = 2,
  parameter int COEF_W   = DEF_COEF_W
) (
  input  logic                         AUD_BCLK,
  input  logic                         reset,
  input  logic                         AUD_DACLRCK,
  input  logic [CHANNELS*DATA_W-1:0]   audio_in,
  input  logic [1:0]                   mode,
  input  logic [COEF_W-1:0]            alpha,
  output logic [CHANNELS*DATA_W-1:0]   audio_out,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  filt_state_t state_q, state_d;

  logic                         lrck_d;
  logic                         frame_edge;
  logic [CH_W-1:0]              ch;
  logic                         last_ch;
  logic [CHANNELS*DATA_W-1:0]   in_q;
  logic [1:0]                   mode_q;
  logic [COEF_W-1:0]            alpha_q;
  logic signed [DATA_W+1:0]     t_q;
  logic signed [DATA_W+1:0]     t_next;
  logic signed [DATA_W+1:0]     x_e, xp_e, yp_e;
  logic signed [DATA_W-1:0]     x_arr  [CHANNELS];
  logic signed [DATA_W-1:0]     x_prev [CHANNELS];
  logic signed [DATA_W-1:0]     y_prev [CHANNELS];
  logic signed [DATA_W-1:0]     out_buf [CHANNELS];
  logic [CHANNELS*DATA_W-1:0]   buf_packed;
  logic signed [DATA_W-1:0]     x_cur;
  logic signed [DATA_W-1:0]     mul_y;
  logic signed [DATA_W-1:0]     y_cur;
  logic                         filtering;

  assign frame_edge = AUD_DACLRCK & ~lrck_d;
  assign last_ch    = (ch == LAST_CH);
  assign busy       = (state_q != IDLE);
  assign filtering  = (mode_q == FILT_LP) || (mode_q == FILT_HP);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign x_arr[c] = in_q[c*DATA_W +: DATA_W];
    assign buf_packed[c*DATA_W +: DATA_W] = out_buf[c];
  end

  assign x_cur = x_arr[ch];

  always_comb begin
    x_e    = {{2{x_cur[DATA_W-1]}}, x_cur};
    xp_e   = {{2{x_prev[ch][DATA_W-1]}}, x_prev[ch]};
    yp_e   = {{2{y_prev[ch][DATA_W-1]}}, y_prev[ch]};
    t_next = '0;
    case (mode_q)
      FILT_HP: t_next = yp_e + x_e - xp_e;
      FILT_LP: t_next = x_e - yp_e;
      default: t_next = '0;
    endcase
  end

  iir_mul_sat #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W)
  ) u_mul (
    .t        (t_q),
    .alpha    (alpha_q),
    .base     (y_prev[ch]),
    .add_base (mode_q == FILT_LP),
    .y        (mul_y)
  );

  // Mode 3 falls through to bypass along with mode 0.
  assign y_cur = filtering ? mul_y : x_cur;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_edge) state_d = PRE;
      PRE:     state_d = MUL;
      MUL:     state_d = last_ch ? DONE : PRE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge AUD_BCLK or posedge reset) begin
    if (reset) begin
      lrck_d    <= 1'b1;
      ch        <= '0;
      in_q      <= '0;
      mode_q    <= FILT_BYPASS;
      alpha_q   <= '0;
      t_q       <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        x_prev[c]  <= '0;
        y_prev[c]  <= '0;
        out_buf[c] <= '0;
      end
    end else begin
      lrck_d    <= AUD_DACLRCK;
      out_valid <= 1'b0;
      if (frame_edge && state_q != IDLE) overrun <= 1'b1;
      case (state_q)
        IDLE: begin
          if (frame_edge) begin
            in_q    <= audio_in;
            mode_q  <= mode;
            alpha_q <= alpha;
            ch      <= '0;
          end
        end
        PRE: t_q <= t_next;
        MUL: begin
          x_prev[ch]  <= x_cur;
          y_prev[ch]  <= y_cur;
          out_buf[ch] <= y_cur;
          if (!last_ch) ch <= ch + CH_W'(1);
        end
        DONE: begin
          audio_out <= buf_packed;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_iir_filter.sv
// Directed self-checking bench for audio_iir_filter (2 channels, 32-bit, Q0.16 alpha).
module tb_audio_iir_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        lrck;
  logic [63:0] audio_in;
  logic [1:0]  mode;
  logic [15:0] alpha;
  logic [63:0] audio_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  audio_iir_filter #(.DATA_W(32), .CHANNELS(2), .COEF_W(16)) dut (
    .AUD_BCLK    (clk),
    .reset       (reset),
    .AUD_DACLRCK (lrck),
    .audio_in    (audio_in),
    .mode        (mode),
    .alpha       (alpha),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    reset = 1'b1;
    lrck  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Raises LR for one capture edge and returns cycles from capture to out_valid (-1 = timeout).
  task automatic run_frame(input logic [31:0] x0, input logic [31:0] x1,
                           input logic [1:0] m, input logic [15:0] al, output int lat);
    audio_in = {x1, x0};
    mode     = m;
    alpha    = al;
    lrck     = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    lrck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; lrck = 1'b0; audio_in = '0; mode = 2'd0; alpha = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (audio_out !== 64'd0) begin failures++; $display("FAIL reset_audio_out got=%h exp=0", audio_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hp_step();
    logic signed [31:0] exp_y [3] = '{32'sd500, 32'sd250, 32'sd125};
    int lat;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(32'd1000, 32'd1000, 2'd2, 16'h8000, lat);
      checks++; if (lat !== 5) begin failures++; $display("FAIL hp_latency frame=%0d got=%0d exp=5", f, lat); end
      checks++; if ($signed(audio_out[31:0]) !== exp_y[f]) begin failures++; $display("FAIL hp_ch0 frame=%0d got=%0d exp=%0d", f, $signed(audio_out[31:0]), exp_y[f]); end
      checks++; if ($signed(audio_out[63:32]) !== exp_y[f]) begin failures++; $display("FAIL hp_ch1 frame=%0d got=%0d exp=%0d", f, $signed(audio_out[63:32]), exp_y[f]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hp_pulse_width frame=%0d got=%b exp=0", f, out_valid); end
    end
  endtask

  task automatic test_lp_step();
    logic signed [31:0] exp_y [3] = '{32'sd250, 32'sd437, 32'sd577};
    int lat;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(32'd1000, 32'd1000, 2'd1, 16'h4000, lat);
      checks++; if (lat !== 5) begin failures++; $display("FAIL lp_latency frame=%0d got=%0d exp=5", f, lat); end
      checks++; if ($signed(audio_out[31:0]) !== exp_y[f]) begin failures++; $display("FAIL lp_ch0 frame=%0d got=%0d exp=%0d", f, $signed(audio_out[31:0]), exp_y[f]); end
      checks++; if ($signed(audio_out[63:32]) !== exp_y[f]) begin failures++; $display("FAIL lp_ch1 frame=%0d got=%0d exp=%0d", f, $signed(audio_out[63:32]), exp_y[f]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_neg_sat();
    int lat;
    apply_reset();
    run_frame(32'd0, 32'd0, 2'd2, 16'h8000, lat);
    @(posedge clk); #1;
    run_frame(-32'sd3, -32'sd3, 2'd2, 16'h8000, lat);
    checks++; if ($signed(audio_out[31:0]) !== -32'sd2) begin failures++; $display("FAIL neg_trunc got=%0d exp=-2", $signed(audio_out[31:0])); end
    @(posedge clk); #1;
    // alpha=0 primes x_prev at the rails while keeping y_prev at 0.
    apply_reset();
    run_frame(32'h8000_0000, 32'h7FFF_FFFF, 2'd2, 16'h0000, lat);
    checks++; if (audio_out !== 64'd0) begin failures++; $display("FAIL sat_prime got=%h exp=0", audio_out); end
    @(posedge clk); #1;
    run_frame(32'h7FFF_FFFF, 32'h8000_0000, 2'd2, 16'hFFFF, lat);
    checks++; if (audio_out[31:0] !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fffffff", audio_out[31:0]); end
    checks++; if (audio_out[63:32] !== 32'h8000_0000) begin failures++; $display("FAIL sat_neg got=%h exp=80000000", audio_out[63:32]); end
    @(posedge clk); #1;
  endtask

  task automatic test_overrun();
    int pulses = 0;
    int lat;
    logic [63:0] seen = '0;
    apply_reset();
    audio_in = {32'd1000, 32'd1000}; mode = 2'd2; alpha = 16'h8000;
    lrck = 1'b1;
    @(posedge clk); #1;
    lrck = 1'b0;
    @(posedge clk); #1;
    lrck = 1'b1;
    audio_in = {32'd9999, 32'd9999};
    @(posedge clk); #1;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overrun_busy got=%b exp=1", busy); end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin pulses++; seen = audio_out; end
    end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", pulses); end
    checks++; if (seen !== {32'd500, 32'd500}) begin failures++; $display("FAIL overrun_result got=%h exp=%h", seen, {32'd500, 32'd500}); end
    lrck = 1'b0;
    @(posedge clk); #1;
    run_frame(32'd1000, 32'd1000, 2'd2, 16'h8000, lat);
    checks++; if (lat !== 5) begin failures++; $display("FAIL overrun_next_latency got=%0d exp=5", lat); end
    checks++; if (audio_out !== {32'd250, 32'd250}) begin failures++; $display("FAIL overrun_next got=%h exp=%h", audio_out, {32'd250, 32'd250}); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int vld = 0;
    int bsy = 0;
    int lat;
    apply_reset();
    audio_in = {32'd1000, 32'd1000}; mode = 2'd2; alpha = 16'h8000;
    lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (audio_out !== 64'd0) begin failures++; $display("FAIL midrst_out got=%h exp=0", audio_out); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) vld++;
      if (busy) bsy++;
    end
    checks++; if (vld !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", vld); end
    checks++; if (bsy !== 0) begin failures++; $display("FAIL midrst_no_frame got=%0d exp=0", bsy); end
    lrck = 1'b0;
    @(posedge clk); #1;
    run_frame(32'd1000, 32'd1000, 2'd2, 16'h8000, lat);
    checks++; if (audio_out !== {32'd500, 32'd500}) begin failures++; $display("FAIL midrst_history got=%h exp=%h", audio_out, {32'd500, 32'd500}); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass_switch();
    int lat;
    apply_reset();
    run_frame(32'd1234, -32'sd77, 2'd0, 16'h8000, lat);
    checks++; if ($signed(audio_out[31:0]) !== 32'sd1234) begin failures++; $display("FAIL bypass_ch0 got=%0d exp=1234", $signed(audio_out[31:0])); end
    checks++; if ($signed(audio_out[63:32]) !== -32'sd77) begin failures++; $display("FAIL bypass_ch1 got=%0d exp=-77", $signed(audio_out[63:32])); end
    @(posedge clk); #1;
    run_frame(32'd1234, -32'sd77, 2'd2, 16'h8000, lat);
    checks++; if ($signed(audio_out[31:0]) !== 32'sd617) begin failures++; $display("FAIL switch_ch0 got=%0d exp=617", $signed(audio_out[31:0])); end
    checks++; if ($signed(audio_out[63:32]) !== -32'sd39) begin failures++; $display("FAIL switch_ch1 got=%0d exp=-39", $signed(audio_out[63:32])); end
    @(posedge clk); #1;
    run_frame(32'd5, -32'sd6, 2'd3, 16'h8000, lat);
    checks++; if (audio_out !== {-32'sd6, 32'sd5}) begin failures++; $display("FAIL mode3_bypass got=%h exp=%h", audio_out, {-32'sd6, 32'sd5}); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_hp_step();
    test_lp_step();
    test_neg_sat();
    test_overrun();
    test_reset_mid();
    test_bypass_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_iir_filter.md
# audio_iir_filter

Parametrised first-order IIR audio filter that supersedes the fixed high-pass stage in the audio path. It supports `CHANNELS` interleaved channels, selectable low-pass, high-pass or bypass mode, a run-time fixed-point coefficient, and signed saturation. It sits between the audio codec receive interface and the DAC transmit interface, running on the bit clock. A frame starts on each rising edge of the DAC LR clock. Channels are processed sequentially through one shared multiplier.

## Interface
- `DATA_W`, 32: signed sample width per channel.
- `CHANNELS`, 2: number of channels; legal range 1..31.
- `COEF_W`, 16: coefficient width, unsigned Q0.COEF_W (alpha = coef / 2^COEF_W).

Ports:
- `AUD_BCLK`  in  1  codec bit clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `AUD_DACLRCK`  in  1  LR clock; its rising edge (sampled on `AUD_BCLK`) starts a frame.
- `audio_in`  in  CHANNELS*DATA_W  signed samples; channel c is at bits [c*DATA_W +: DATA_W].
- `mode`  in  2  0 bypass, 1 low-pass, 2 high-pass, 3 treated as bypass.
- `alpha`  in  COEF_W  filter coefficient.
- `audio_out`  out  CHANNELS*DATA_W  filtered samples, registered, same packing as `audio_in`.
- `out_valid`  out  1  one-cycle pulse when `audio_out` updates.
- `busy`  out  1  high while a frame is being processed.
- `overrun`  out  1  sticky; set when a frame edge arrives while busy; cleared only by reset.

## Operation
- Edge detect: `lrck_d` <= `AUD_DACLRCK` every cycle. A frame edge is `AUD_DACLRCK` & ~`lrck_d`. `lrck_d` resets to 1, so an LR clock that is already high coming out of reset does not start a frame.
- FSM states:
  - IDLE: on a frame edge, capture `audio_in`, `mode` and `alpha` into frame registers, set channel index ch=0, go to PRE.
  - PRE: compute the term t for channel ch, go to MUL.
  - MUL: compute the result y, update per-channel state, write the output buffer. If ch<CHANNELS-1, increment ch and go to PRE; otherwise go to DONE.
  - DONE: copy the buffer to `audio_out`, pulse `out_valid`, go to IDLE.
- Per-channel state: `x_prev[c]`, `y_prev[c]`, both DATA_W signed, reset to 0.
- High-pass: t = y_prev + x − x_prev; y = sat((t·alpha) >>> COEF_W).
- Low-pass: t = x − y_prev; y = sat(y_prev + ((t·alpha) >>> COEF_W)).
- Bypass: y = x.
- In all modes, MUL writes `x_prev`<=x and `y_prev`<=y. Switching modes therefore starts from consistent history.
- Arithmetic:
  - t is DATA_W+2 bits signed.
  - The product is DATA_W+2+COEF_W+1 bits signed; alpha is zero-extended.
  - The shift is arithmetic, which truncates toward −inf.
  - sat clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- `mode` and `alpha` are latched at frame start. Changes mid-frame take effect on the next frame.
- A frame edge while not in IDLE: the edge is ignored, `overrun` is set, and the current frame completes unchanged.

## Timing
- Frame edge detected at clock edge k (the capture edge).
- Channel c: PRE at k+1+2c, MUL at k+2+2c.
- DONE at edge k+2·CHANNELS+1: `audio_out` updates and `out_valid`=1 for exactly that cycle.
- Latency from capture to `out_valid` is 2·CHANNELS+1 cycles.
- `busy` is high from k+1 through the DONE cycle inclusive.
- A new frame edge in the cycle after DONE is accepted.
- Reset values:
  - `audio_out`=0, `out_valid`=0, `busy`=0, `overrun`=0.
  - All `x_prev` and `y_prev` = 0; FSM in IDLE; `lrck_d`=1.
- Reset asserted mid-frame: the FSM aborts to IDLE immediately and all state clears. No `out_valid` is issued for the aborted frame.

## Structure
- Package `audio_filter_pkg`:
  - mode constants `FILT_BYPASS`=2'd0, `FILT_LP`=2'd1, `FILT_HP`=2'd2;
  - FSM state enum (IDLE, PRE, MUL, DONE);
  - default `DATA_W` and `COEF_W`.
- Sub-module `iir_mul_sat`: combinational signed t×alpha, arithmetic shift, optional y_prev add, and saturation to DATA_W. It is instantiated once and shared across channels.
- Top level holds the edge detect, FSM, channel counter, state arrays and output buffer.

## Test plan
- **HP step.** Defaults, mode=2, alpha=0x8000, both channels step 0→1000 held for three frames.
  - Required: outputs 500, 250, 125.
  - Required: `out_valid` exactly 5 cycles after each capture edge.
- **LP step.** mode=1, alpha=0x4000, x=1000 held.
  - Required: outputs 250, 437, 577.
- **Negative truncation and saturation.**
  - HP, alpha=0x8000, x 0→−3: required y=−2.
  - HP, alpha=0xFFFF, x −2^31→2^31−1: required y=0x7FFFFFFF.
  - Mirrored input: required y=0x80000000.
- **Overrun.** A second LR rising edge 2 cycles after the first.
  - Required: the second edge is ignored and `overrun`=1.
  - Required: the output equals the first frame's result; the next normal edge is processed.
- **Reset.**
  - Assert reset during channel 1 PRE: required all outputs 0, `busy`=0, no `out_valid`.
  - Release reset with LR clock held high: required no frame until the next rising edge.
- **Bypass and mode switch.** mode=0 with x=1234 / −77 on channels 0 / 1.
  - Required: out 1234 / −77.
  - Then switch to HP with alpha=0x8000 and the same x: required out 617 / −39.
